// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory stage. Passes ALU results through and runs
//            loads/stores against a byte-serial memory controller.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int OPT_W = 6,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [OPT_W-1:0] inst_i,
    input  logic [4:0]       rd_i,
    input  logic [XLEN-1:0]  vd_i,
    input  logic [XLEN-1:0]  addr_i,
    input  logic             w_enable_i,
    output logic             mem_req,
    output logic             mem_rw,
    output logic [XLEN-1:0]  mem_addr,
    output logic [1:0]       mem_len,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_done,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [OPT_W-1:0] inst_o,
    output logic [4:0]       rd_o,
    output logic [XLEN-1:0]  vd_o,
    output logic             w_enable_o,
    output logic             stall_req,
    output logic             load_busy
);

    localparam logic [OPT_W-1:0] OP_ZERO = OPT_W'(0);
    localparam logic [OPT_W-1:0] OP_LB   = OPT_W'(20);
    localparam logic [OPT_W-1:0] OP_LH   = OPT_W'(21);
    localparam logic [OPT_W-1:0] OP_LW   = OPT_W'(22);
    localparam logic [OPT_W-1:0] OP_LBU  = OPT_W'(23);
    localparam logic [OPT_W-1:0] OP_LHU  = OPT_W'(24);
    localparam logic [OPT_W-1:0] OP_SB   = OPT_W'(25);
    localparam logic [OPT_W-1:0] OP_SH   = OPT_W'(26);
    localparam logic [OPT_W-1:0] OP_SW   = OPT_W'(27);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [OPT_W-1:0] op_q;
    logic [XLEN-1:0]  result;

    function automatic logic is_load(input logic [OPT_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [OPT_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] len_of(input logic [OPT_W-1:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB)
            return 2'd0;
        else if (op == OP_LH || op == OP_LHU || op == OP_SH)
            return 2'd1;
        else
            return 2'd3;
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [OPT_W-1:0] op,
                                               input logic [XLEN-1:0]  d);
        if (op == OP_LB)
            return {{(XLEN-8){d[7]}}, d[7:0]};
        else if (op == OP_LH)
            return {{(XLEN-16){d[15]}}, d[15:0]};
        else if (op == OP_LBU)
            return {{(XLEN-8){1'b0}}, d[7:0]};
        else if (op == OP_LHU)
            return {{(XLEN-16){1'b0}}, d[15:0]};
        else if (op == OP_LW)
            return d;
        else
            return '0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else if (rdy)
            state <= next_state;
    end

    // DONE always returns to IDLE so the still-present memory opcode cannot relaunch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (is_load(inst_i) || is_store(inst_i)) next_state = S_BUSY;
            S_BUSY: if (mem_done) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_len   <= 2'd0;
            mem_wdata <= '0;
            result    <= '0;
            op_q      <= '0;
        end else if (rdy) begin
            if (state == S_IDLE && (is_load(inst_i) || is_store(inst_i))) begin
                mem_req   <= 1'b1;
                mem_rw    <= is_store(inst_i);
                mem_addr  <= addr_i;
                mem_len   <= len_of(inst_i);
                mem_wdata <= vd_i;
                op_q      <= inst_i;
            end else if (state == S_BUSY && mem_done) begin
                mem_req <= 1'b0;
                result  <= extend(op_q, mem_rdata);
            end
        end
    end

    always_comb begin
        inst_o     = inst_i;
        rd_o       = rd_i;
        vd_o       = vd_i;
        w_enable_o = w_enable_i;
        stall_req  = 1'b0;
        load_busy  = 1'b0;
        if (rst) begin
            inst_o     = '0;
            rd_o       = '0;
            vd_o       = '0;
            w_enable_o = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_load(inst_i) || is_store(inst_i)) begin
                        stall_req  = 1'b1;
                        w_enable_o = 1'b0;
                        vd_o       = '0;
                        load_busy  = is_load(inst_i);
                    end else if (inst_i == OP_ZERO) begin
                        rd_o       = '0;
                        w_enable_o = 1'b0;
                    end
                end
                S_BUSY: begin
                    stall_req  = 1'b1;
                    w_enable_o = 1'b0;
                    vd_o       = '0;
                    load_busy  = is_load(op_q);
                end
                S_DONE: begin
                    vd_o       = result;
                    w_enable_o = is_load(op_q) ? w_enable_i : 1'b0;
                end
                default: begin
                    stall_req = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// Directed bench for mem_stage with an expected-result scoreboard.
module tb_mem_stage;

    localparam logic [5:0] OP_ZERO = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_LB   = 6'd20;
    localparam logic [5:0] OP_LH   = 6'd21;
    localparam logic [5:0] OP_LW   = 6'd22;
    localparam logic [5:0] OP_LBU  = 6'd23;
    localparam logic [5:0] OP_LHU  = 6'd24;
    localparam logic [5:0] OP_SH   = 6'd26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [5:0]  inst_i = '0;
    logic [4:0]  rd_i = '0;
    logic [31:0] vd_i = '0;
    logic [31:0] addr_i = '0;
    logic        w_enable_i = 1'b0;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_done = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [5:0]  inst_o;
    logic [4:0]  rd_o;
    logic [31:0] vd_o;
    logic        w_enable_o;
    logic        stall_req;
    logic        load_busy;

    mem_stage #(.OPT_W(6), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .inst_i(inst_i), .rd_i(rd_i), .vd_i(vd_i), .addr_i(addr_i),
        .w_enable_i(w_enable_i),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .inst_o(inst_o), .rd_o(rd_o), .vd_o(vd_o), .w_enable_o(w_enable_o),
        .stall_req(stall_req), .load_busy(load_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  inst;
        logic [4:0]  rd;
        logic [31:0] vd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] inst, input logic [4:0] rd,
                        input logic [31:0] vd, input logic we);
        exp_t e;
        e.inst = inst; e.rd = rd; e.vd = vd; e.we = we;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_inst"}, 32'(inst_o), 32'(e.inst));
            chk({tag, "_rd"},   32'(rd_o),   32'(e.rd));
            chk({tag, "_vd"},   vd_o,        e.vd);
            chk({tag, "_we"},   32'(w_enable_o), 32'(e.we));
        end
    endtask

    task automatic run_alu(input string tag, input logic [5:0] op, input logic [4:0] rd,
                           input logic [31:0] vd, input logic we,
                           input logic [4:0] exp_rd, input logic exp_we);
        @(negedge clk);
        inst_i = op; rd_i = rd; vd_i = vd; w_enable_i = we; addr_i = 32'h0;
        push(op, exp_rd, vd, exp_we);
        #1;
        chk({tag, "_stall"}, 32'(stall_req), 32'd0);
        chk({tag, "_req"},   32'(mem_req),   32'd0);
        pop_check(tag);
    endtask

    // mem_done is raised on the n-th cycle of mem_req, completing that access.
    task automatic run_mem(input string tag, input logic [5:0] op, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int n,
                           input logic [31:0] exp_vd, input logic exp_we,
                           input logic ld, input logic [1:0] len, input logic rw);
        @(negedge clk);
        inst_i = op; rd_i = rd; vd_i = data; addr_i = addr; w_enable_i = 1'b1;
        mem_done = 1'b0;
        push(op, rd, exp_vd, exp_we);
        #1;
        chk({tag, "_enter_stall"}, 32'(stall_req), 32'd1);
        chk({tag, "_enter_lbusy"}, 32'(load_busy), 32'(ld));
        chk({tag, "_enter_req"},   32'(mem_req),   32'd0);
        chk({tag, "_enter_we"},    32'(w_enable_o), 32'd0);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            mem_done  = (k == n);
            mem_rdata = (k == n) ? rdata : 32'h0;
            #1;
            chk({tag, "_busy_req"},   32'(mem_req),   32'd1);
            chk({tag, "_busy_stall"}, 32'(stall_req), 32'd1);
            chk({tag, "_busy_lbusy"}, 32'(load_busy), 32'(ld));
            if (k == 1) begin
                chk({tag, "_len"},   32'(mem_len), 32'(len));
                chk({tag, "_rw"},    32'(mem_rw),  32'(rw));
                chk({tag, "_addr"},  mem_addr,     addr);
                chk({tag, "_wdata"}, mem_wdata,    data);
            end
        end
        @(negedge clk);
        mem_done = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk({tag, "_done_stall"}, 32'(stall_req), 32'd0);
        chk({tag, "_done_lbusy"}, 32'(load_busy), 32'd0);
        chk({tag, "_done_req"},   32'(mem_req),   32'd0);
        pop_check({tag, "_done"});
    endtask

    initial begin
        // Reset: combinational outputs and registers read zero.
        inst_i = OP_ADD; rd_i = 5'd5; vd_i = 32'h1234; w_enable_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vd",    vd_o,              32'h0);
        chk("rst_we",    32'(w_enable_o),   32'd0);
        chk("rst_stall", 32'(stall_req),    32'd0);
        chk("rst_req",   32'(mem_req),      32'd0);
        chk("rst_addr",  mem_addr,          32'h0);
        chk("rst_len",   32'(mem_len),      32'd0);
        rst = 1'b0;

        run_alu("add",  OP_ADD,  5'd5, 32'h1234, 1'b1, 5'd5, 1'b1);
        run_alu("zero", OP_ZERO, 5'd9, 32'h0,    1'b1, 5'd0, 1'b0);

        run_mem("lw",  OP_LW,  5'd10, 32'h1000, 32'h0, 32'hDEADBEEF, 3,
                32'hDEADBEEF, 1'b1, 1'b1, 2'd3, 1'b0);
        run_alu("after_lw", OP_ADD, 5'd1, 32'h77, 1'b1, 5'd1, 1'b1);
        @(negedge clk); #1;
        chk("lw_no_rereq", 32'(mem_req), 32'd0);

        run_mem("lb",  OP_LB,  5'd11, 32'h10, 32'h0, 32'h00000080, 1,
                32'hFFFFFF80, 1'b1, 1'b1, 2'd0, 1'b0);
        run_mem("lbu", OP_LBU, 5'd12, 32'h11, 32'h0, 32'h00000080, 2,
                32'h00000080, 1'b1, 1'b1, 2'd0, 1'b0);
        run_mem("lh",  OP_LH,  5'd13, 32'h12, 32'h0, 32'h00008001, 1,
                32'hFFFF8001, 1'b1, 1'b1, 2'd1, 1'b0);
        run_mem("lhu", OP_LHU, 5'd14, 32'h13, 32'h0, 32'hFFFF8001, 1,
                32'h00008001, 1'b1, 1'b1, 2'd1, 1'b0);
        run_mem("sh",  OP_SH,  5'd15, 32'h2003, 32'hAABBCCDD, 32'h0, 2,
                32'h0, 1'b0, 1'b0, 2'd1, 1'b1);

        // rdy low during BUSY: pulses on mem_done are ignored.
        @(negedge clk);
        inst_i = OP_LW; rd_i = 5'd9; addr_i = 32'h3000; vd_i = 32'h0; w_enable_i = 1'b1;
        push(OP_LW, 5'd9, 32'h12345678, 1'b1);
        #1;
        chk("rdy_enter_stall", 32'(stall_req), 32'd1);
        @(negedge clk); #1;
        chk("rdy_busy_req", 32'(mem_req), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rdy = 1'b0; mem_done = 1'b1; mem_rdata = 32'h0BAD0BAD;
            #1;
            chk("rdy_low_req",   32'(mem_req),   32'd1);
            chk("rdy_low_stall", 32'(stall_req), 32'd1);
            chk("rdy_low_addr",  mem_addr,       32'h3000);
        end
        @(negedge clk);
        rdy = 1'b1; mem_done = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("rdy_back_req",   32'(mem_req),   32'd1);
        @(negedge clk);
        mem_done = 1'b1; mem_rdata = 32'h12345678;
        #1;
        chk("rdy_back_stall", 32'(stall_req), 32'd1);
        @(negedge clk);
        mem_done = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("rdy_done_stall", 32'(stall_req), 32'd0);
        pop_check("rdy_done");

        // Reset mid-BUSY abandons the access.
        @(negedge clk);
        inst_i = OP_LW; rd_i = 5'd3; addr_i = 32'h4000; vd_i = 32'h0; w_enable_i = 1'b1;
        #1;
        chk("rstb_enter_stall", 32'(stall_req), 32'd1);
        @(negedge clk); #1;
        chk("rstb_busy_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstb_comb_stall", 32'(stall_req), 32'd0);
        chk("rstb_comb_vd",    vd_o,           32'h0);
        chk("rstb_comb_lbusy", 32'(load_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        inst_i = OP_ADD; rd_i = 5'd7; vd_i = 32'h55; w_enable_i = 1'b1;
        push(OP_ADD, 5'd7, 32'h55, 1'b1);
        #1;
        chk("rstb_req",   32'(mem_req),   32'd0);
        chk("rstb_addr",  mem_addr,       32'h0);
        chk("rstb_stall", 32'(stall_req), 32'd0);
        pop_check("rstb_add");
        @(negedge clk); #1;
        chk("rstb_idle_req", 32'(mem_req), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage, fed through the EX/MEM latch.
- Non-memory instructions pass straight through to the MEM/WB latch.
- Loads and stores run a small FSM against the byte-serial memory controller, stalling the pipeline until the access completes.
- Loads are sign- or zero-extended here; the stage also gives ID forwarding and load-hazard information.

Parameters:
- OPT_W, 6, width of the shared opcode encoding (same opcode defines as ID/EX).
- XLEN, 32, data and address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- inst_i  in  OPT_W  opcode from EX/MEM latch
- rd_i  in  5  destination register
- vd_i  in  XLEN  ALU result, or store data for stores
- addr_i  in  XLEN  effective address (loads/stores)
- w_enable_i  in  1  register write enable
- mem_req  out  1  request to memory controller (registered)
- mem_rw  out  1  1 = write, 0 = read (registered)
- mem_addr  out  XLEN  access address (registered)
- mem_len  out  2  bytes-1: 0 = byte, 1 = half, 3 = word (registered)
- mem_wdata  out  XLEN  store data (registered)
- mem_done  in  1  one-cycle pulse: access complete
- mem_rdata  in  XLEN  load data, zero-extended by controller, valid with mem_done
- inst_o  out  OPT_W  opcode to MEM/WB
- rd_o  out  5  destination register to MEM/WB and ID forwarding
- vd_o  out  XLEN  write-back value to MEM/WB and ID forwarding
- w_enable_o  out  1  register write enable to MEM/WB
- stall_req  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- load_busy  out  1  load in flight, rd_o not yet valid; ID must stall on match

Behaviour:
- Reset (synchronous, rst high at posedge):
  - State goes to IDLE.
  - mem_req, mem_rw, mem_len go to 0; mem_addr, mem_wdata and the result register go to 0.
  - Combinational outputs read 0 while rst is high.
- rdy low: no register or state updates. mem_done is ignored; the controller is frozen by the same rdy.
- IDLE:
  - Non-memory inst_i: pass-through in the same cycle (inst_o = inst_i, rd_o = rd_i, vd_o = vd_i, w_enable_o = w_enable_i), with stall_req = 0 and load_busy = 0.
  - ZeroOpt gives rd_o = 0 and w_enable_o = 0.
  - Memory inst_i (LB/LH/LW/LBU/LHU/SB/SH/SW):
    - Combinationally: stall_req = 1, w_enable_o = 0, vd_o = 0.
    - load_busy = 1 for loads.
    - Next edge: state goes to BUSY. Latch mem_addr = addr_i, mem_wdata = vd_i, mem_rw = store, mem_len per width; set mem_req = 1.
- BUSY:
  - stall_req = 1, w_enable_o = 0, load_busy = 1 for loads.
  - mem_req stays high and all mem_* fields stay stable until mem_done is sampled high.
  - On mem_done: mem_req goes to 0 and state goes to DONE.
  - Result register captures:
    - LB: sign-extend rdata[7:0].
    - LH: sign-extend rdata[15:0].
    - LW: rdata.
    - LBU/LHU: zero-extend rdata[7:0] / rdata[15:0].
    - Stores: 0.
- DONE (exactly one cycle):
  - stall_req = 0 and load_busy = 0.
  - inst_o = inst_i, rd_o = rd_i, vd_o = result register.
  - w_enable_o = w_enable_i for loads, 0 for stores.
  - Next edge: state goes to IDLE and the upstream latch advances. The memory inst_i still present in DONE must NOT restart an access.
- Latency: load/store result reaches MEM/WB N+2 cycles after entering the stage, where N = cycles from mem_req high to mem_done (N ≥ 1).
- Back-to-back memory instructions each run their own full IDLE→BUSY→DONE cycle; no overlap.
- mem_done seen in IDLE or DONE: ignored.
- Addresses go to the controller unchanged. The controller is byte-serial, so misaligned half/word accesses are legal.
- Reset mid-BUSY: access is abandoned, mem_req drops at that edge, no write-back is produced.

Test Plan:
- ADD, rd=5, vd_i=0x1234: same-cycle vd_o=0x1234, w_enable_o=1, stall_req=0, mem_req never high.
- LW, addr_i=0x1000, mem_done 3 cycles after mem_req with rdata=0xDEADBEEF:
  - mem_req/mem_len=3/mem_rw=0 held for 3 cycles.
  - stall_req high throughout.
  - DONE cycle shows vd_o=0xDEADBEEF, w_enable_o=1.
  - No second request.
- LB rdata=0x00000080 → vd_o=0xFFFFFF80; LBU same data → 0x00000080; LH rdata=0x8001 → 0xFFFF8001.
- SH, addr_i=0x2003, vd_i=0xAABBCCDD → mem_rw=1, mem_len=1, mem_addr=0x2003, mem_wdata=0xAABBCCDD; DONE shows w_enable_o=0.
- rdy low for 4 cycles during BUSY with mem_done asserted there: state and mem_* unchanged, pulse ignored; after rdy returns, the next mem_done completes normally.
- rst pulsed during BUSY: next cycle mem_req=0, state IDLE, outputs 0; the following ADD passes through normally.
